// File: rtl/execute_stage.sv
// EX stage of a 64-bit in-order pipeline: ALU, branch target and branch decision,
// captured into the EX/MEM register with stall/flush control.
`ifndef WORD
`define WORD 64
`endif

module execute_stage (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [`WORD-1:0]  cur_pc_in,
  input  logic [`WORD-1:0]  read_data1_in,
  input  logic [`WORD-1:0]  read_data2_in,
  input  logic [`WORD-1:0]  sign_extended_in,
  input  logic [10:0]       opcode_in,
  input  logic [1:0]        alu_op_in,
  input  logic              alu_src_in,
  input  logic              branch_in,
  input  logic              uncondbranch_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic [4:0]        write_register_in,
  output logic [`WORD-1:0]  alu_result,
  output logic [`WORD-1:0]  branch_target,
  output logic [`WORD-1:0]  read_data2,
  output logic              zero,
  output logic              pc_src,
  output logic              illegal_op,
  output logic              valid,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic [4:0]        write_register
);

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;

  logic [`WORD-1:0] operand_b;
  logic [`WORD-1:0] alu_next;
  logic             illegal_next;
  logic             zero_next;
  logic             live;

  always_comb begin
    operand_b    = alu_src_in ? sign_extended_in : read_data2_in;
    alu_next     = read_data1_in + operand_b;
    illegal_next = 1'b0;
    case (alu_op_in)
      2'b01: alu_next = operand_b;
      2'b10: begin
        case (opcode_in)
          OP_ADD:  alu_next = read_data1_in + operand_b;
          OP_SUB:  alu_next = read_data1_in - operand_b;
          OP_AND:  alu_next = read_data1_in & operand_b;
          OP_ORR:  alu_next = read_data1_in | operand_b;
          default: illegal_next = 1'b1;
        endcase
      end
      default: alu_next = read_data1_in + operand_b;
    endcase
  end

  assign zero_next = (alu_next == '0);
  // A flush or an empty decode slot both become a bubble on the control side.
  assign live      = valid_in & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result     <= '0;
      branch_target  <= '0;
      read_data2     <= '0;
      zero           <= 1'b0;
      pc_src         <= 1'b0;
      illegal_op     <= 1'b0;
      valid          <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_to_reg     <= 1'b0;
      reg_write      <= 1'b0;
      write_register <= '0;
    end else if (!stall || flush) begin
      alu_result     <= alu_next;
      branch_target  <= cur_pc_in + (sign_extended_in << 2);
      read_data2     <= read_data2_in;
      zero           <= zero_next;
      pc_src         <= live & (uncondbranch_in | (branch_in & zero_next));
      illegal_op     <= live & illegal_next;
      valid          <= live;
      mem_read       <= live & mem_read_in;
      mem_write      <= live & mem_write_in;
      mem_to_reg     <= mem_to_reg_in;
      reg_write      <= live & reg_write_in;
      write_register <= write_register_in;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the EX/MEM register.
`timescale 1ns/1ps

module tb_execute_stage;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  // Control bits that must be known zero after a flush (pc_src..mem_write, reg_write).
  localparam logic [204:0] CTRL_MASK = 205'hFA0;
  localparam logic [204:0] ALL_MASK  = {205{1'b1}};

  logic clk = 1'b0;
  logic reset, stall, flush, valid_in;
  logic [63:0] cur_pc_in, read_data1_in, read_data2_in, sign_extended_in;
  logic [10:0] opcode_in;
  logic [1:0]  alu_op_in;
  logic alu_src_in, branch_in, uncondbranch_in;
  logic mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
  logic [4:0] write_register_in;
  logic [63:0] alu_result, branch_target, read_data2;
  logic zero, pc_src, illegal_op, valid, mem_read, mem_write, mem_to_reg, reg_write;
  logic [4:0] write_register;

  logic [204:0] obs;
  logic [204:0] model_state;
  logic         model_known;
  logic [204:0] exp_q[$];
  logic [204:0] exp;
  logic [204:0] held;
  int checks = 0;
  int failures = 0;

  execute_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .cur_pc_in(cur_pc_in), .read_data1_in(read_data1_in), .read_data2_in(read_data2_in),
    .sign_extended_in(sign_extended_in), .opcode_in(opcode_in), .alu_op_in(alu_op_in),
    .alu_src_in(alu_src_in), .branch_in(branch_in), .uncondbranch_in(uncondbranch_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .reg_write_in(reg_write_in), .write_register_in(write_register_in),
    .alu_result(alu_result), .branch_target(branch_target), .read_data2(read_data2),
    .zero(zero), .pc_src(pc_src), .illegal_op(illegal_op), .valid(valid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .write_register(write_register)
  );

  always #5 clk = ~clk;

  assign obs = {alu_result, branch_target, read_data2, zero, pc_src, illegal_op, valid,
                mem_read, mem_write, mem_to_reg, reg_write, write_register};

  task automatic set_idle();
    stall = 0; flush = 0; valid_in = 0;
    cur_pc_in = 0; read_data1_in = 0; read_data2_in = 0; sign_extended_in = 0;
    opcode_in = 0; alu_op_in = 0; alu_src_in = 0; branch_in = 0; uncondbranch_in = 0;
    mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0; reg_write_in = 0;
    write_register_in = 0;
  endtask

  // Reference: what the pipeline register should hold after the coming edge.
  task automatic tick();
    logic [63:0] a, b, r;
    logic ill, live, z;
    if (!(stall && !flush)) begin
      a = read_data1_in;
      b = alu_src_in ? sign_extended_in : read_data2_in;
      ill = 1'b0;
      if (alu_op_in == 2'b01) r = b;
      else if (alu_op_in == 2'b10) begin
        if (opcode_in == OP_SUB) r = a - b;
        else if (opcode_in == OP_AND) r = a & b;
        else if (opcode_in == OP_ORR) r = a | b;
        else begin
          r = a + b;
          ill = (opcode_in != OP_ADD);
        end
      end else r = a + b;
      live = valid_in && !flush;
      z = (r == 64'd0);
      model_state = {r, cur_pc_in + sign_extended_in * 64'd4, read_data2_in, z,
                     live && (uncondbranch_in || (branch_in && z)), live && ill, live,
                     live && mem_read_in, live && mem_write_in, mem_to_reg_in,
                     live && reg_write_in, write_register_in};
      model_known = !flush;
    end
    exp_q.push_back(model_state);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 0;
    set_idle();
    #3;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", obs);
    end
    model_state = '0;
    model_known = 1'b1;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_ldur();
    @(negedge clk);
    set_idle();
    valid_in = 1; read_data1_in = 16; sign_extended_in = 64; alu_src_in = 1;
    alu_op_in = 2'b00; mem_read_in = 1; mem_to_reg_in = 1; reg_write_in = 1;
    write_register_in = 5'd3;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL ldur_state got=%h want=%h", obs, exp); end
    checks++;
    if (alu_result !== 64'd80 || zero !== 1'b0) begin
      failures++; $display("FAIL ldur_result got=%0d zero=%b want=80 zero=0", alu_result, zero);
    end
    checks++;
    if (mem_read !== 1'b1 || valid !== 1'b1 || reg_write !== 1'b1) begin
      failures++; $display("FAIL ldur_ctrl got mr=%b v=%b rw=%b want 1 1 1", mem_read, valid, reg_write);
    end
  endtask

  task automatic test_add_sub();
    @(negedge clk);
    set_idle();
    valid_in = 1; read_data1_in = 10; read_data2_in = 20; alu_op_in = 2'b10;
    opcode_in = OP_ADD; reg_write_in = 1;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (alu_result !== 64'd30 || obs !== exp) begin
      failures++; $display("FAIL add_result got=%0d want=30", alu_result);
    end
    @(negedge clk);
    read_data1_in = 5; read_data2_in = 7; opcode_in = OP_SUB;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (alu_result !== 64'hFFFF_FFFF_FFFF_FFFE || zero !== 1'b0 || read_data2 !== 64'd7) begin
      failures++; $display("FAIL sub_result got=%h zero=%b want=fffffffffffffffe zero=0", alu_result, zero);
    end
    @(negedge clk);
    read_data1_in = 64'hF0F0; read_data2_in = 64'h0FF0; opcode_in = OP_AND;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (alu_result !== 64'h00F0 || obs !== exp) begin
      failures++; $display("FAIL and_result got=%h want=f0", alu_result);
    end
  endtask

  task automatic test_cbz();
    @(negedge clk);
    set_idle();
    valid_in = 1; cur_pc_in = 8; sign_extended_in = 3; read_data2_in = 0;
    alu_op_in = 2'b01; branch_in = 1;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (branch_target !== 64'd20 || zero !== 1'b1 || pc_src !== 1'b1) begin
      failures++; $display("FAIL cbz_taken got tgt=%0d zero=%b pc_src=%b want 20 1 1", branch_target, zero, pc_src);
    end
    @(negedge clk);
    read_data2_in = 1;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (pc_src !== 1'b0 || zero !== 1'b0 || obs !== exp) begin
      failures++; $display("FAIL cbz_not_taken got pc_src=%b zero=%b want 0 0", pc_src, zero);
    end
  endtask

  task automatic test_stall_flush();
    @(negedge clk);
    set_idle();
    valid_in = 1; read_data1_in = 10; read_data2_in = 20; alu_op_in = 2'b10;
    opcode_in = OP_ADD; reg_write_in = 1; write_register_in = 5'd9;
    tick();
    exp = exp_q.pop_front();
    held = obs;
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL stall_load got=%h want=%h", obs, exp); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      stall = 1; read_data1_in = 64'd99 + i; opcode_in = OP_SUB; write_register_in = 5'd1;
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp || alu_result !== 64'd30 || write_register !== 5'd9) begin
        failures++; $display("FAIL stall_hold cycle=%0d got=%h want=%h", i, obs, exp);
      end
    end
    @(negedge clk);
    stall = 1; flush = 1;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (valid !== 1'b0 || reg_write !== 1'b0 || pc_src !== 1'b0 || (obs & CTRL_MASK) !== (exp & CTRL_MASK)) begin
      failures++; $display("FAIL stall_flush got v=%b rw=%b pc_src=%b want 0 0 0", valid, reg_write, pc_src);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    set_idle();
    valid_in = 1; uncondbranch_in = 1; cur_pc_in = 64'h100; sign_extended_in = 5;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (pc_src !== 1'b1 || branch_target !== 64'h114) begin
      failures++; $display("FAIL b_taken got pc_src=%b tgt=%h want 1 114", pc_src, branch_target);
    end
    #2;
    reset = 0;
    #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_async got=%h want=0", obs); end
    model_state = '0;
    model_known = 1'b1;
    @(negedge clk);
    set_idle();
    valid_in = 1; read_data1_in = 64'hF0; read_data2_in = 64'h0F; alu_op_in = 2'b10;
    opcode_in = OP_ORR; reg_write_in = 1;
    reset = 1;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (alu_result !== 64'hFF || valid !== 1'b1 || obs !== exp) begin
      failures++; $display("FAIL orr_after_reset got=%h v=%b want ff 1", alu_result, valid);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    set_idle();
    valid_in = 1; read_data1_in = 1; read_data2_in = 2; alu_op_in = 2'b10;
    opcode_in = 11'b11111111111;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (alu_result !== 64'd3 || illegal_op !== 1'b1 || obs !== exp) begin
      failures++; $display("FAIL illegal got=%0d ill=%b want 3 1", alu_result, illegal_op);
    end
    @(negedge clk);
    valid_in = 0;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (illegal_op !== 1'b0 || valid !== 1'b0 || obs !== exp) begin
      failures++; $display("FAIL bubble_clears got ill=%b v=%b want 0 0", illegal_op, valid);
    end
  endtask

  task automatic test_random();
    logic [10:0] ops [5];
    logic [204:0] mask;
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_ORR; ops[4] = 11'h7FF;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      valid_in = ($urandom_range(0, 4) != 0);
      cur_pc_in = {$urandom, $urandom};
      read_data1_in = {$urandom, $urandom};
      read_data2_in = ($urandom_range(0, 3) == 0) ? read_data1_in : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) read_data2_in = 0;
      sign_extended_in = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
      opcode_in = ops[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) opcode_in = 11'($urandom);
      alu_op_in = 2'($urandom_range(0, 3));
      alu_src_in = 1'($urandom_range(0, 1));
      branch_in = 1'($urandom_range(0, 1));
      uncondbranch_in = ($urandom_range(0, 5) == 0);
      mem_read_in = 1'($urandom_range(0, 1));
      mem_write_in = 1'($urandom_range(0, 1));
      mem_to_reg_in = 1'($urandom_range(0, 1));
      reg_write_in = 1'($urandom_range(0, 1));
      write_register_in = 5'($urandom);
      tick();
      exp = exp_q.pop_front();
      mask = model_known ? ALL_MASK : CTRL_MASK;
      checks++;
      if ((obs & mask) !== (exp & mask)) begin
        failures++;
        $display("FAIL random_%0d got=%h want=%h", i, obs & mask, exp & mask);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldur();
    test_add_sub();
    test_cbz();
    test_stall_flush();
    test_reset_mid_op();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have no parameters; datapath width is `WORD (64), opcode width 11.
REQ-002 clk  input  1  stage clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; clears the EX/MEM register on assertion regardless of clk.
REQ-004 stall  input  1  hold EX/MEM register contents.
REQ-005 flush  input  1  insert bubble at next edge.
REQ-006 valid_in  input  1  decode stage holds a live instruction.
REQ-007 cur_pc_in  input  64  PC of instruction in decode.
REQ-008 read_data1_in, read_data2_in, sign_extended_in  input  64 each  decode operands.
REQ-009 opcode_in  input  11  instruction opcode field.
REQ-010 alu_op_in  input  2  ALUOp from decode control.
REQ-011 alu_src_in, branch_in, uncondbranch_in  input  1 each  decode control.
REQ-012 mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in  input  1 each  passthrough control.
REQ-013 write_register_in  input  5  destination register.
REQ-014 alu_result, branch_target, read_data2  output  64 each  registered results.
REQ-015 zero, pc_src, illegal_op, valid  output  1 each  registered status.
REQ-016 mem_read, mem_write, mem_to_reg, reg_write  output  1 each  registered passthrough control.
REQ-017 write_register  output  5  registered destination.

Function
REQ-018 Operand B SHALL be sign_extended_in when alu_src_in=1, else read_data2_in.
REQ-019 ALU control: alu_op 00 -> A+B; 01 -> pass B; 10 -> decode opcode: ADD 10001011000 -> A+B, SUB 11001011000 -> A-B, AND 10001010000 -> A&B, ORR 10101010000 -> A|B; 11 -> A+B.
REQ-020 alu_op=10 with unlisted opcode SHALL compute A+B and set illegal_op=1; illegal_op=0 otherwise.
REQ-021 All arithmetic SHALL be 64-bit modulo 2^64; no carry/overflow output.
REQ-022 zero SHALL be 1 iff the 64-bit ALU result equals 0.
REQ-023 branch_target SHALL be cur_pc_in + (sign_extended_in << 2), modulo 2^64.
REQ-024 pc_src SHALL be valid_in & (uncondbranch_in | (branch_in & zero_next)).
REQ-025 Latency SHALL be exactly one cycle: values computed from inputs present before edge N appear on outputs after edge N.
REQ-026 read_data2 output SHALL carry read_data2_in (store data), not operand B.
REQ-027 stall=1, flush=0: every output SHALL hold its previous value.
REQ-028 flush=1 SHALL clear valid, pc_src, reg_write, mem_read, mem_write, illegal_op at next edge, regardless of stall; datapath outputs MAY update.
REQ-029 valid_in=0 SHALL be treated as flush for control outputs (bubble propagates).
REQ-030 Outputs SHALL be glitch-free registered values; no combinational input-to-output path.

Reset
REQ-031 While reset=0, all outputs SHALL be 0 asynchronously, including mid-instruction.
REQ-032 First edge after reset deassertion SHALL capture inputs normally; no extra bubble.

Verification
REQ-033 LDUR: A=16, imm=64, alu_src=1, alu_op=00, mem_read/mem_to_reg/reg_write=1 -> after one edge alu_result=80, zero=0, mem_read=1, valid=1.
REQ-034 ADD: A=10, read_data2=20, alu_op=10, opcode ADD -> alu_result=30; then SUB A=5, B=7 -> alu_result=0xFFFFFFFFFFFFFFFE, zero=0.
REQ-035 CBZ: cur_pc=8, imm=3, read_data2=0, alu_op=01, branch=1 -> branch_target=20, zero=1, pc_src=1; same with read_data2=1 -> pc_src=0.
REQ-036 Stall then flush: load ADD, assert stall two cycles -> outputs unchanged; assert stall+flush together -> valid=0, reg_write=0, pc_src=0.
REQ-037 Reset mid-op: B instruction registered (pc_src=1), drive reset=0 between edges -> all outputs 0 immediately; release, ORR A=0xF0, B=0x0F -> alu_result=0xFF.
REQ-038 Illegal: alu_op=10, opcode 11111111111, A=1, B=2 -> alu_result=3, illegal_op=1.
